qpu_event_timing_queue: RTL and testbench

//  Receiving end of the QIU write-back channel: accepts timed quantum events {tdata, edata, oprand},

---
 rtl/qpu_event_timing_queue.sv | 154 +++++++++++++++
 tb/tb_qpu_event_timing_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_event_timing_queue.sv
`default_nettype none
// ============================================================================
//  Module   : qpu_event_timing_queue
//  Summary  : Timed event FIFO; issues each event when the local timeline
//             reaches its timestamp and exports the timeline to the QIU.
//  Revision : 1.0  initial release
// ============================================================================
module qpu_event_timing_queue #(
   parameter int EW    = 64,
   parameter int EN    = 8,
   parameter int TW    = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     evq_i_valid,
   output logic                     evq_i_ready,
   input  logic [TW-1:0]            evq_i_tdata,
   input  logic [EW-1:0]            evq_i_edata,
   input  logic [EN-1:0]            evq_i_oprand,
   input  logic                     evq_i_start,
   input  logic                     evq_i_stop,
   output logic [TW-1:0]            evq_o_clk,
   output logic                     evq_o_evt_valid,
   output logic [EW-1:0]            evq_o_edata,
   output logic [EN-1:0]            evq_o_oprand,
   output logic                     evq_o_late,
   output logic                     evq_o_empty,
   output logic [$clog2(DEPTH):0]   evq_o_count
);

   localparam int c_pw = $clog2(DEPTH);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_run  = 1'b1;

   logic [0:0]    r_state;
   logic [0:0]    w_state_nxt;
   logic          w_run;

   logic [TW-1:0] r_mem_tdata  [DEPTH];
   logic [EW-1:0] r_mem_edata  [DEPTH];
   logic [EN-1:0] r_mem_oprand [DEPTH];

   logic [c_pw:0] r_wr_ptr;
   logic [c_pw:0] r_rd_ptr;
   logic [c_pw:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_behind;

   logic [TW-1:0] r_timeline;
   logic [TW-1:0] w_head_tdata;
   logic [TW-1:0] w_delta;

   logic          r_evt_valid;
   logic [EW-1:0] r_edata;
   logic [EN-1:0] r_oprand;
   logic          r_late;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (evq_i_start) begin
         w_state_nxt = c_st_run;
      end else if (evq_i_stop) begin
         w_state_nxt = c_st_idle;
      end
   end

   always_comb begin
      w_run = (r_state == c_st_run);
   end

   // ---------------------------------------------------------------- FIFO
   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_full      = (w_count == (c_pw+1)'(DEPTH));
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_push      = evq_i_valid & ~w_full;
   assign evq_i_ready = ~w_full;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_tdata[r_wr_ptr[c_pw-1:0]]  <= evq_i_tdata;
         r_mem_edata[r_wr_ptr[c_pw-1:0]]  <= evq_i_edata;
         r_mem_oprand[r_wr_ptr[c_pw-1:0]] <= evq_i_oprand;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // ---------------------------------------------------------------- timeline / issue
   // Modular difference: MSB set means the head timestamp is already in the past.
   assign w_head_tdata = r_mem_tdata[r_rd_ptr[c_pw-1:0]];
   assign w_delta      = w_head_tdata - r_timeline;
   assign w_behind     = w_delta[TW-1];
   assign w_pop        = w_run & ~w_empty & ((w_delta == '0) | w_behind);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeline <= '0;
      end else if (evq_i_start) begin
         r_timeline <= '0;
      end else if (w_run && !evq_i_stop) begin
         r_timeline <= r_timeline + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evt_valid <= 1'b0;
         r_edata     <= '0;
         r_oprand    <= '0;
         r_late      <= 1'b0;
      end else begin
         r_evt_valid <= w_pop;
         r_edata     <= w_pop ? r_mem_edata[r_rd_ptr[c_pw-1:0]]  : '0;
         r_oprand    <= w_pop ? r_mem_oprand[r_rd_ptr[c_pw-1:0]] : '0;
         if (evq_i_start) begin
            r_late <= 1'b0;
         end else if (w_pop && w_behind) begin
            r_late <= 1'b1;
         end
      end
   end

   assign evq_o_clk       = r_timeline;
   assign evq_o_evt_valid = r_evt_valid;
   assign evq_o_edata     = r_edata;
   assign evq_o_oprand    = r_oprand;
   assign evq_o_late      = r_late;
   assign evq_o_empty     = w_empty;
   assign evq_o_count     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_qpu_event_timing_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qpu_event_timing_queue
//  Summary  : Directed self-checking bench for qpu_event_timing_queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qpu_event_timing_queue;
   localparam int EW = 64, EN = 8, TW = 32, DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          valid, start, stop, ready;
   logic [TW-1:0] tdata, o_clk;
   logic [EW-1:0] edata, o_edata;
   logic [EN-1:0] oprand, o_oprand;
   logic          evt_valid, late, empty;
   logic [3:0]    count;

   logic          valid2, start2, stop2, ready2;
   logic [7:0]    tdata2, o_clk2;
   logic [EW-1:0] edata2, o_edata2;
   logic [EN-1:0] oprand2, o_oprand2;
   logic          evt_valid2, late2, empty2;
   logic [2:0]    count2;

   int checks = 0;
   int errors = 0;

   qpu_event_timing_queue #(.EW(EW), .EN(EN), .TW(TW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .evq_i_valid(valid), .evq_i_ready(ready), .evq_i_tdata(tdata),
      .evq_i_edata(edata), .evq_i_oprand(oprand),
      .evq_i_start(start), .evq_i_stop(stop),
      .evq_o_clk(o_clk), .evq_o_evt_valid(evt_valid), .evq_o_edata(o_edata),
      .evq_o_oprand(o_oprand), .evq_o_late(late), .evq_o_empty(empty),
      .evq_o_count(count)
   );

   qpu_event_timing_queue #(.EW(EW), .EN(EN), .TW(8), .DEPTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .evq_i_valid(valid2), .evq_i_ready(ready2), .evq_i_tdata(tdata2),
      .evq_i_edata(edata2), .evq_i_oprand(oprand2),
      .evq_i_start(start2), .evq_i_stop(stop2),
      .evq_o_clk(o_clk2), .evq_o_evt_valid(evt_valid2), .evq_o_edata(o_edata2),
      .evq_o_oprand(o_oprand2), .evq_o_late(late2), .evq_o_empty(empty2),
      .evq_o_count(count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 0; start = 0; stop = 0; tdata = '0; edata = '0; oprand = '0;
      valid2 = 0; start2 = 0; stop2 = 0; tdata2 = '0; edata2 = '0; oprand2 = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", ready); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %0b want 0", evt_valid); end
      checks++; if (late !== 1'b0) begin errors++; $display("FAIL reset_late: got %0b want 0", late); end
      checks++; if (o_clk !== 32'd0) begin errors++; $display("FAIL reset_clk: got %0d want 0", o_clk); end
      checks++; if (o_edata !== 64'd0 || o_oprand !== 8'd0) begin
         errors++; $display("FAIL reset_data: got %0h/%0h want 0/0", o_edata, o_oprand); end
      checks++; if (o_clk2 !== 8'd0 || ready2 !== 1'b1) begin
         errors++; $display("FAIL reset_dut2: clk %0d ready %0b want 0/1", o_clk2, ready2); end
   endtask

   task automatic test_single_issue();
      int strobes = 0;
      pulse_start();
      checks++; if (o_clk !== 32'd0) begin errors++; $display("FAIL start_clk: got %0d want 0", o_clk); end
      tick(); tick();
      valid = 1; tdata = 32'd10; edata = 64'hA5; oprand = 8'h01;
      tick();
      valid = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (evt_valid) begin
            strobes++;
            checks++; if (o_clk !== 32'd11) begin errors++; $display("FAIL single_time: got %0d want 11", o_clk); end
            checks++; if (o_edata !== 64'hA5 || o_oprand !== 8'h01) begin
               errors++; $display("FAIL single_data: got %0h/%0h want a5/1", o_edata, o_oprand); end
            checks++; if (late !== 1'b0) begin errors++; $display("FAIL single_late: got %0b want 0", late); end
         end else begin
            checks++; if (o_edata !== 64'd0) begin errors++; $display("FAIL idle_edata: got %0h want 0", o_edata); end
         end
      end
      checks++; if (strobes != 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", strobes); end
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] frozen;
      logic          pre_ready;
      logic [EN-1:0] exp_op;
      int            idx = 0;
      stop = 1; tick(); stop = 0;
      frozen = o_clk;
      tick();
      checks++; if (o_clk !== frozen) begin errors++; $display("FAIL stop_freeze: got %0d want %0d", o_clk, frozen); end
      for (int i = 0; i < DEPTH; i++) begin
         valid = 1; tdata = 32'(5 + i); edata = 64'(32'h100 + i); oprand = 8'd1 << i;
         tick();
      end
      checks++; if (count !== 4'd8 || ready !== 1'b0) begin
         errors++; $display("FAIL full: count %0d ready %0b want 8/0", count, ready); end
      tdata = 32'd13; edata = 64'h108; oprand = 8'hFF;
      tick(); tick();
      checks++; if (count !== 4'd8 || ready !== 1'b0 || empty !== 1'b0) begin
         errors++; $display("FAIL holdoff: count %0d ready %0b empty %0b want 8/0/0", count, ready, empty); end
      pulse_start();
      for (int n = 0; n < 30; n++) begin
         pre_ready = ready;
         tick();
         if (valid && pre_ready) valid = 0;
         if (evt_valid) begin
            exp_op = (idx < 8) ? (8'd1 << idx) : 8'hFF;
            checks++; if (o_clk !== 32'(6 + idx) || o_edata !== 64'(32'h100 + idx) || o_oprand !== exp_op) begin
               errors++; $display("FAIL order_%0d: clk %0d data %0h op %0h want %0d/%0h/%0h",
                                  idx, o_clk, o_edata, o_oprand, 6 + idx, 32'h100 + idx, exp_op); end
            if (idx == 0) begin
               checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_return: got %0b want 1", ready); end
            end
            idx++;
         end
         if (o_clk == 32'd7) begin
            checks++; if (count !== 4'd7) begin errors++; $display("FAIL push_pop_count: got %0d want 7", count); end
         end
      end
      checks++; if (idx != 9 || empty !== 1'b1 || late !== 1'b0) begin
         errors++; $display("FAIL drain: issued %0d empty %0b late %0b want 9/1/0", idx, empty, late); end
   endtask

   task automatic test_late();
      pulse_start();
      repeat (20) tick();
      checks++; if (o_clk !== 32'd20) begin errors++; $display("FAIL late_setup: got %0d want 20", o_clk); end
      valid = 1; tdata = 32'd5; edata = 64'h55; oprand = 8'h80;
      tick();
      valid = 0;
      tick();
      checks++; if (evt_valid !== 1'b1 || o_edata !== 64'h55 || o_oprand !== 8'h80 || late !== 1'b1) begin
         errors++; $display("FAIL late_issue: v %0b data %0h op %0h late %0b want 1/55/80/1",
                            evt_valid, o_edata, o_oprand, late); end
      repeat (5) tick();
      checks++; if (late !== 1'b1 || evt_valid !== 1'b0) begin
         errors++; $display("FAIL late_sticky: late %0b v %0b want 1/0", late, evt_valid); end
   endtask

   task automatic test_equal_ts();
      int n = 0;
      pulse_start();
      checks++; if (late !== 1'b0 || o_clk !== 32'd0) begin
         errors++; $display("FAIL start_clear: late %0b clk %0d want 0/0", late, o_clk); end
      valid = 1; tdata = 32'd30; edata = 64'h301; oprand = 8'h03; tick();
      edata = 64'h302; oprand = 8'h0C; tick();
      valid = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (evt_valid) begin
            if (n == 0) begin
               checks++; if (o_clk !== 32'd31 || o_edata !== 64'h301 || late !== 1'b0) begin
                  errors++; $display("FAIL eq_first: clk %0d data %0h late %0b want 31/301/0", o_clk, o_edata, late); end
            end else begin
               checks++; if (o_clk !== 32'd32 || o_edata !== 64'h302 || late !== 1'b1) begin
                  errors++; $display("FAIL eq_second: clk %0d data %0h late %0b want 32/302/1", o_clk, o_edata, late); end
            end
            n++;
         end
      end
      checks++; if (n != 2) begin errors++; $display("FAIL eq_strobes: got %0d want 2", n); end
   endtask

   task automatic test_wrap();
      int n = 0;
      start2 = 1; tick(); start2 = 0;
      repeat (250) tick();
      checks++; if (o_clk2 !== 8'd250) begin errors++; $display("FAIL wrap_setup: got %0d want 250", o_clk2); end
      valid2 = 1; tdata2 = 8'd3; edata2 = 64'hBEEF; oprand2 = 8'h5A;
      tick();
      valid2 = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (evt_valid2) begin
            n++;
            checks++; if (o_clk2 !== 8'd4 || o_edata2 !== 64'hBEEF || o_oprand2 !== 8'h5A || late2 !== 1'b0) begin
               errors++; $display("FAIL wrap_issue: clk %0d data %0h op %0h late %0b want 4/beef/5a/0",
                                  o_clk2, o_edata2, o_oprand2, late2); end
         end
      end
      checks++; if (n != 1) begin errors++; $display("FAIL wrap_strobes: got %0d want 1", n); end
   endtask

   task automatic test_reset_midop();
      valid = 1; tdata = 32'd100000; edata = 64'h1; oprand = 8'h1;
      tick();
      valid = 0;
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL midop_setup: got %0d want 1", count); end
      rst_n = 1'b0;
      #1;
      checks++; if (count !== 4'd0 || empty !== 1'b1 || ready !== 1'b1 || o_clk !== 32'd0 || late !== 1'b0) begin
         errors++; $display("FAIL midop_reset: count %0d empty %0b ready %0b clk %0d late %0b want 0/1/1/0/0",
                            count, empty, ready, o_clk, late); end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_issue();
      test_backpressure();
      test_late();
      test_equal_ts();
      test_wrap();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
